// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
//   BW        : binary width per channel
//   ND        : BCD digits per output channel
//   MAXV      : largest value representable in ND digits
//   CLAMP_BCD : packed BCD written when a channel is out of range
//   SR_W      : dabble register width (ND+1 BCD nibbles plus BW binary bits)
//   state_e   : converter FSM states
package bcd_pkg;

   localparam int BW   = 10;
   localparam int ND   = 3;
   localparam int MAXV = 999;

   function automatic int bcd_w(input int nd);
      return 4 * nd;
   endfunction

   localparam int DW   = bcd_w(ND);
   // One extra (thousands) nibble absorbs every value up to 2**BW-1.
   localparam int SR_W = bcd_w(ND + 1) + BW;
   localparam int IT_W = $clog2(BW);

   localparam logic [DW-1:0] CLAMP_BCD = 12'h999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } state_e;

endpackage

// File: rtl/bin2bcd_seq_dabble_step.sv
// dabble_step: one combinational double-dabble iteration.
//   sr_i : {BCD nibbles, binary bits} before the iteration
//   sr_o : every BCD nibble >= 5 corrected by +3, then the whole vector
//          shifted left by one
module dabble_step
   import bcd_pkg::*;
(
   input  logic [SR_W-1:0] sr_i,
   output logic [SR_W-1:0] sr_o
);

   logic [SR_W-1:0] adj;

   always_comb begin
      adj = sr_i;
      for (int k = 0; k <= ND; k++) begin
         if (sr_i[BW + 4*k +: 4] >= 4'd5)
            adj[BW + 4*k +: 4] = sr_i[BW + 4*k +: 4] + 4'd3;
      end
      sr_o = {adj[SR_W-2:0], 1'b0};
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: three-channel binary-to-BCD converter sharing one
// double-dabble datapath. Channels are converted in turn into staging
// registers and published together so the display never mixes old and new.
//   clk            : clock
//   RST            : synchronous reset, active-high
//   start          : conversion request, sampled only in IDLE
//   bin0..bin2     : binary inputs, snapshotted on accepted start
//   busy           : high while converting and during the done cycle
//   done           : one-cycle pulse, outputs updated in that cycle
//   dec0..dec2     : packed BCD results (hundreds in [11:8])
//   ovf            : bit k set when bin_k exceeded MAXV
module bin2bcd_seq
   import bcd_pkg::*;
(
   input  logic          clk,
   input  logic          RST,
   input  logic          start,
   input  logic [BW-1:0] bin0,
   input  logic [BW-1:0] bin1,
   input  logic [BW-1:0] bin2,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] dec0,
   output logic [DW-1:0] dec1,
   output logic [DW-1:0] dec2,
   output logic [2:0]    ovf
);

   state_e                state_q, state_d;
   logic [1:0]            ch_q, ch_d;
   logic [IT_W-1:0]       it_q, it_d;
   logic [SR_W-1:0]       sr_q, sr_d;
   logic [2:0][BW-1:0]    snap_q, snap_d;
   logic [2:0][DW-1:0]    stage_q, stage_d;
   logic [2:0]            ovf_stage_q, ovf_stage_d;
   logic [2:0][DW-1:0]    dec_q, dec_d;
   logic [2:0]            ovf_q, ovf_d;
   logic                  done_q, done_d;
   logic [SR_W-1:0]       step_out;

   dabble_step u_step (
      .sr_i (sr_q),
      .sr_o (step_out)
   );

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      it_d        = it_q;
      sr_d        = sr_q;
      snap_d      = snap_q;
      stage_d     = stage_q;
      ovf_stage_d = ovf_stage_q;
      dec_d       = dec_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snap_d  = {bin2, bin1, bin0};
               ch_d    = 2'd0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            sr_d    = {{(SR_W-BW){1'b0}}, snap_q[ch_q]};
            it_d    = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sr_d = step_out;
            it_d = it_q + IT_W'(1);
            if (it_q == IT_W'(BW-1))
               state_d = ST_STORE;
         end
         ST_STORE: begin
            // Nonzero thousands digit means the value is above MAXV.
            if (sr_q[SR_W-1 -: 4] != 4'd0) begin
               stage_d[ch_q]     = CLAMP_BCD;
               ovf_stage_d[ch_q] = 1'b1;
            end else begin
               stage_d[ch_q]     = sr_q[BW +: DW];
               ovf_stage_d[ch_q] = 1'b0;
            end
            if (ch_q < 2'd2) begin
               ch_d    = ch_q + 2'd1;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            dec_d   = stage_q;
            ovf_d   = ovf_stage_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         it_q        <= '0;
         sr_q        <= '0;
         snap_q      <= '0;
         stage_q     <= '0;
         ovf_stage_q <= '0;
         dec_q       <= '0;
         ovf_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         it_q        <= it_d;
         sr_q        <= sr_d;
         snap_q      <= snap_d;
         stage_q     <= stage_d;
         ovf_stage_q <= ovf_stage_d;
         dec_q       <= dec_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   // done is registered, so it lands in the cycle after DONE; keep busy up
   // through that cycle so consumers see busy drop only after the results.
   assign busy = (state_q != ST_IDLE) || done_q;
   assign done = done_q;
   assign dec0 = dec_q[0];
   assign dec1 = dec_q[1];
   assign dec2 = dec_q[2];
   assign ovf  = ovf_q;

endmodule
